inst_ram_arbiter: RTL

//   Shares one single-port, 1-cycle-read-latency instruction RAM between two requesters:

---
 rtl/iram_arb_pkg.sv | 25 ++
 rtl/inst_ram_arbiter_if.sv | 27 ++
 rtl/iram_arb_rr.sv | 36 +++
 rtl/inst_ram_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/iram_arb_pkg.sv
// Shared constants and response-tracking types for the instruction RAM arbiter.
// Port 0 is CPU instruction fetch; port 1 is the program loader/debug port.
package iram_arb_pkg;

    localparam int unsigned PORT_FETCH = 0;
    localparam int unsigned PORT_LOAD  = 1;
    localparam int unsigned NPORTS     = 2;
    localparam int unsigned PORT_W     = 1;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_PEND,
        RSP_HOLD
    } rsp_state_e;

    typedef struct packed {
        rsp_state_e          state;
        logic [PORT_W-1:0]   port;
    } rsp_track_t;

    function automatic logic [NPORTS-1:0] port_onehot(input logic [PORT_W-1:0] p);
        return NPORTS'(1) << p;
    endfunction

endpackage

// File: rtl/inst_ram_arbiter_if.sv
// Requester-side bus of the instruction RAM arbiter: two request ports and
// their read-response handshakes. master = requesters, slave = arbiter.
interface inst_ram_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
);
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_we;
    logic [AW-1:0] req_addr0;
    logic [AW-1:0] req_addr1;
    logic [DW-1:0] req_wdata0;
    logic [DW-1:0] req_wdata1;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/iram_arb_rr.sv
// Two-way round-robin picker. On a tie the port not granted last wins;
// last_grant moves only on an actual grant and resets to port 1 so port 0 wins first.
module iram_arb_rr (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    import iram_arb_pkg::*;

    logic last_grant_q, last_grant_d;

    always_comb begin
        gnt = '0;
        if (en) begin
            case (req)
                2'b01:   gnt[PORT_FETCH] = 1'b1;
                2'b10:   gnt[PORT_LOAD]  = 1'b1;
                2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (|gnt) last_grant_d = gnt[PORT_LOAD];
    end

    always_ff @(posedge clk) begin
        if (reset) last_grant_q <= 1'b1;
        else       last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/inst_ram_arbiter.sv
// Shares a single-port, 1-cycle-latency instruction RAM between fetch and loader ports.
// Optional build macro IRAM_ARB_PERF_EN enables the grant/conflict perf counters.
module inst_ram_arbiter #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
) (
    input  logic                clk,
    input  logic                reset,
    inst_ram_arbiter_if.slave   bus,
    output logic                ram_we,
    output logic [AW-1:0]       ram_a,
    output logic [DW-1:0]       ram_d,
    input  logic [DW-1:0]       ram_spo,
    output logic [31:0]         perf_grant0,
    output logic [31:0]         perf_grant1,
    output logic [31:0]         perf_conflict
);
    import iram_arb_pkg::*;

    rsp_track_t    rsp_q, rsp_d;
    logic [DW-1:0] hold_data_q, hold_data_d;
    logic [AW-1:0] ram_a_q, ram_a_d;
    logic [DW-1:0] ram_d_q, ram_d_d;
    logic          can_grant;
    logic [1:0]    gnt;
    logic          grant_any;
    logic          gnt_port;
    logic          gnt_we;

    // A pending read may be retired and replaced in the same cycle only if its consumer is ready.
    always_comb begin
        can_grant = 1'b0;
        if (!reset) begin
            case (rsp_q.state)
                RSP_IDLE: can_grant = 1'b1;
                RSP_PEND: can_grant = bus.rsp_ready[rsp_q.port];
                default:  can_grant = 1'b0;
            endcase
        end
    end

    iram_arb_rr u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (bus.req_valid),
        .en    (can_grant),
        .gnt   (gnt)
    );

    assign grant_any     = |gnt;
    assign gnt_port      = gnt[PORT_LOAD];
    assign gnt_we        = grant_any & bus.req_we[gnt_port];
    assign bus.req_ready = gnt;

    always_comb begin
        ram_a_d = ram_a_q;
        ram_d_d = ram_d_q;
        if (gnt[PORT_FETCH]) begin
            ram_a_d = bus.req_addr0;
            ram_d_d = bus.req_wdata0;
        end else if (gnt[PORT_LOAD]) begin
            ram_a_d = bus.req_addr1;
            ram_d_d = bus.req_wdata1;
        end
    end

    assign ram_we = gnt_we;
    assign ram_a  = ram_a_d;
    assign ram_d  = ram_d_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_q       <= '{state: RSP_IDLE, port: '0};
            hold_data_q <= '0;
            ram_a_q     <= '0;
            ram_d_q     <= '0;
        end else begin
            rsp_q       <= rsp_d;
            hold_data_q <= hold_data_d;
            ram_a_q     <= ram_a_d;
            ram_d_q     <= ram_d_d;
        end
    end

    // An unconsumed read result is parked in hold because ram_spo changes next cycle.
    always_comb begin
        rsp_d       = rsp_q;
        hold_data_d = hold_data_q;
        case (rsp_q.state)
            RSP_IDLE: ;
            RSP_PEND: begin
                if (bus.rsp_ready[rsp_q.port]) begin
                    rsp_d.state = RSP_IDLE;
                end else begin
                    rsp_d.state = RSP_HOLD;
                    hold_data_d = ram_spo;
                end
            end
            RSP_HOLD: if (bus.rsp_ready[rsp_q.port]) rsp_d.state = RSP_IDLE;
            default:  rsp_d.state = RSP_IDLE;
        endcase
        if (grant_any && !gnt_we) begin
            rsp_d.state = RSP_PEND;
            rsp_d.port  = gnt_port;
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_rdata = '0;
        if (!reset) begin
            case (rsp_q.state)
                RSP_PEND: begin
                    bus.rsp_valid = port_onehot(rsp_q.port);
                    bus.rsp_rdata = ram_spo;
                end
                RSP_HOLD: begin
                    bus.rsp_valid = port_onehot(rsp_q.port);
                    bus.rsp_rdata = hold_data_q;
                end
                default: ;
            endcase
        end
    end

`ifdef IRAM_ARB_PERF_EN
    logic [31:0] grant0_q, grant0_d;
    logic [31:0] grant1_q, grant1_d;
    logic [31:0] conflict_q, conflict_d;

    always_comb begin
        grant0_d   = grant0_q + 32'(gnt[PORT_FETCH]);
        grant1_d   = grant1_q + 32'(gnt[PORT_LOAD]);
        conflict_d = conflict_q + 32'((bus.req_valid == 2'b11) && can_grant);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant0_q   <= '0;
            grant1_q   <= '0;
            conflict_q <= '0;
        end else begin
            grant0_q   <= grant0_d;
            grant1_q   <= grant1_d;
            conflict_q <= conflict_d;
        end
    end

    assign perf_grant0   = grant0_q;
    assign perf_grant1   = grant1_q;
    assign perf_conflict = conflict_q;
`else
    assign perf_grant0   = '0;
    assign perf_grant1   = '0;
    assign perf_conflict = '0;
`endif

endmodule
